// File: rtl/conv1_pkg.sv
// Shared constants and state encoding for the Convolution 1 layer sequencer.
package conv1_pkg;

  localparam int IMG_W  = 28;
  localparam int K      = 5;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int KTAPS  = K * K;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    CONV,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/conv1_win_addr.sv
// Window walker: r/c/kr/kc counters with incremental image and output addresses.
// img_addr_o always shows the tap currently being issued; flags decode that tap.
module conv1_win_addr
  import conv1_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init_i,
  input  logic       step_i,
  output logic [9:0] img_addr_o,
  output logic [9:0] out_addr_o,
  output logic       first_o,
  output logic       last_o,
  output logic       final_o
);

  // Address deltas for moving to the next kernel row, next window, next output row.
  localparam logic [9:0] ROW_STEP = 10'(IMG_W - K + 1);
  localparam logic [9:0] WIN_SPAN = 10'((K - 1) * IMG_W + (K - 1));
  localparam logic [9:0] NEXT_ROW = 10'(IMG_W - OUT_W + 1);

  logic [4:0] r_q, r_d, c_q, c_d;
  logic [2:0] kr_q, kr_d, kc_q, kc_d;
  logic [9:0] img_q, img_d, oa_q, oa_d;
  logic       kc_end, kr_end, c_end, r_end;

  assign kc_end = (kc_q == 3'(K - 1));
  assign kr_end = (kr_q == 3'(K - 1));
  assign c_end  = (c_q == 5'(OUT_W - 1));
  assign r_end  = (r_q == 5'(OUT_W - 1));

  always_comb begin
    r_d   = r_q;
    c_d   = c_q;
    kr_d  = kr_q;
    kc_d  = kc_q;
    img_d = img_q;
    oa_d  = oa_q;
    if (init_i) begin
      r_d   = '0;
      c_d   = '0;
      kr_d  = '0;
      kc_d  = '0;
      img_d = '0;
      oa_d  = '0;
    end else if (step_i) begin
      if (!kc_end) begin
        kc_d  = kc_q + 3'd1;
        img_d = img_q + 10'd1;
      end else if (!kr_end) begin
        kc_d  = '0;
        kr_d  = kr_q + 3'd1;
        img_d = img_q + ROW_STEP;
      end else begin
        kc_d = '0;
        kr_d = '0;
        oa_d = oa_q + 10'd1;
        if (!c_end) begin
          c_d   = c_q + 5'd1;
          img_d = img_q - WIN_SPAN + 10'd1;
        end else begin
          c_d   = '0;
          r_d   = r_q + 5'd1;
          img_d = img_q - WIN_SPAN + NEXT_ROW;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= '0;
      c_q   <= '0;
      kr_q  <= '0;
      kc_q  <= '0;
      img_q <= '0;
      oa_q  <= '0;
    end else begin
      r_q   <= r_d;
      c_q   <= c_d;
      kr_q  <= kr_d;
      kc_q  <= kc_d;
      img_q <= img_d;
      oa_q  <= oa_d;
    end
  end

  assign img_addr_o = img_q;
  assign out_addr_o = oa_q;
  assign first_o    = (kr_q == 3'd0) && (kc_q == 3'd0);
  assign last_o     = kr_end && kc_end;
  assign final_o    = r_end && c_end && kr_end && kc_end;

endmodule

// File: rtl/conv1_layer_ctrl.sv
// Convolution 1 layer sequencer: kernel load, window sweep, MAC strobes and
// output writes, with memory read latency absorbed by MEM_LAT-deep shift registers.
module conv1_layer_ctrl
  import conv1_pkg::*;
#(
  parameter int K1_BASE = 25,
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [5:0] k_addr0,
  output logic [5:0] k_addr1,
  output logic       k_load_en,
  output logic [4:0] k_load_idx,
  output logic [9:0] img_addr,
  output logic       mac_valid,
  output logic       mac_clear,
  output logic       mac_last,
  output logic       out_we,
  output logic [9:0] out_addr,
  output logic       busy,
  output logic       done
);

  state_e state_q, state_d;

  logic [5:0]              k_addr0_q, k_addr1_q;
  logic [MEM_LAT-1:0]      kv_q, mv_q, mf_q, ml_q;
  logic [MEM_LAT-1:0][4:0] ki_q;
  logic [MEM_LAT-1:0][9:0] oa_q;
  logic                    out_we_q, busy_q, done_q;
  logic [9:0]              out_addr_q;
  logic [9:0]              win_img_addr, win_out_addr;
  logic                    win_first, win_last, win_final;
  logic                    accept, issue_k, issue_c, k_end, pipe_empty;

  assign accept     = (state_q == IDLE) && start;
  assign issue_k    = (state_q == LOAD_K);
  assign issue_c    = (state_q == CONV);
  assign k_end      = (k_addr0_q == 6'(KTAPS - 1));
  assign pipe_empty = (mv_q == '0) && !out_we_q;

  conv1_win_addr u_win (
    .clk        (clk),
    .reset      (reset),
    .init_i     (accept),
    .step_i     (issue_c && !win_final),
    .img_addr_o (win_img_addr),
    .out_addr_o (win_out_addr),
    .first_o    (win_first),
    .last_o     (win_last),
    .final_o    (win_final)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_K;
      LOAD_K:  if (k_end) state_d = CONV;
      CONV:    if (win_final) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_addr0_q  <= '0;
      k_addr1_q  <= 6'(K1_BASE);
      kv_q       <= '0;
      mv_q       <= '0;
      mf_q       <= '0;
      ml_q       <= '0;
      ki_q       <= '0;
      oa_q       <= '0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == LOAD_K) || (state_d == CONV) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
      if (accept) begin
        k_addr0_q <= '0;
        k_addr1_q <= 6'(K1_BASE);
      end else if (issue_k && !k_end) begin
        k_addr0_q <= k_addr0_q + 6'd1;
        k_addr1_q <= k_addr1_q + 6'd1;
      end
      // Issue-time flags enter stage 0; stage MEM_LAT-1 lines up with read data.
      kv_q[0] <= issue_k;
      ki_q[0] <= k_addr0_q[4:0];
      mv_q[0] <= issue_c;
      mf_q[0] <= issue_c && win_first;
      ml_q[0] <= issue_c && win_last;
      oa_q[0] <= win_out_addr;
      for (int i = 1; i < MEM_LAT; i++) begin
        kv_q[i] <= kv_q[i-1];
        ki_q[i] <= ki_q[i-1];
        mv_q[i] <= mv_q[i-1];
        mf_q[i] <= mf_q[i-1];
        ml_q[i] <= ml_q[i-1];
        oa_q[i] <= oa_q[i-1];
      end
      out_we_q <= ml_q[MEM_LAT-1];
      if (ml_q[MEM_LAT-1]) out_addr_q <= oa_q[MEM_LAT-1];
    end
  end

  assign k_addr0    = k_addr0_q;
  assign k_addr1    = k_addr1_q;
  assign k_load_en  = kv_q[MEM_LAT-1];
  assign k_load_idx = ki_q[MEM_LAT-1];
  assign img_addr   = win_img_addr;
  assign mac_valid  = mv_q[MEM_LAT-1];
  assign mac_clear  = mf_q[MEM_LAT-1];
  assign mac_last   = ml_q[MEM_LAT-1];
  assign out_we     = out_we_q;
  assign out_addr   = out_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
